alu_rr_scheduler: RTL and testbench

//  Shares one combinational ALU_8bit between NUM_REQ requesters.

---
 rtl/alu_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/alu_rr_scheduler.sv | 179 +++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// ----------------------------------------------------------------------------
// alu_sched_pkg
//   Shared types and constants for the round-robin ALU scheduler.
//   - state_e : scheduler FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   - DATA_W  : operand/result width of the shared ALU_8bit
//   - SEL_W   : ALU_SEL opcode width (forwarded undecoded)
// ----------------------------------------------------------------------------
package alu_sched_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Scans req starting at index ptr and
//   wrapping modulo NUM_REQ; the first asserted request wins.
// Ports
//   req          in   NUM_REQ  request vector
//   ptr          in   ID_W     index with highest priority (must be < NUM_REQ)
//   grant_onehot out  NUM_REQ  one-hot grant, zero when nothing requests
//   grant_idx    out  ID_W     index of the granted request (0 when !any)
//   any          out  1        at least one request asserted
// ----------------------------------------------------------------------------
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  // Walk the priority order from lowest to highest priority so the last
  // match written (offset 0 from ptr) is the winner.
  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req[idx]) begin
        grant_onehot      = '0;
        grant_onehot[idx] = 1'b1;
        grant_idx         = ID_W'(idx);
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// ----------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one combinational ALU_8bit between NUM_REQ requesters. A
//   round-robin grant registers the winner's operands onto the ALU, the ALU
//   settles for one cycle, and the captured result is returned with the
//   requester id over a single response channel.
//
// Handshake rules (both channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   Request side: req_ready is combinational from req_valid and is only ever
//   raised in IDLE, one-hot on the granted requester. Requesters hold
//   req_valid and operands until they see req_ready; dropping req_valid
//   earlier withdraws the request. Response side: rsp_valid is registered
//   (state == RESP) and every rsp_* field holds until rsp_valid && rsp_ready.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake
//   req_a/req_b/req_sel   packed operands, requester i at [i*W +: W]
//   alu_a/alu_b/alu_sel   registered operands driven to ALU_8bit
//   alu_out/carry/zero    combinational results from ALU_8bit
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/out/carry/zero captured response fields
//   busy                  high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          alu_sel,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_carry,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_out,
  output logic                      rsp_carry,
  output logic                      rsp_zero,
  output logic                      busy
);

  // FSM state is kept in a plainly named register so checkers can bind to it.
  state_e state;
  state_e state_next;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic               accept;
  logic               rsp_fire;

  logic [DATA_W-1:0]  a_mux;
  logic [DATA_W-1:0]  b_mux;
  logic [SEL_W-1:0]   sel_mux;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

  // Operand select driven by the one-hot grant, so no wide index arithmetic.
  always_comb begin
    a_mux   = '0;
    b_mux   = '0;
    sel_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_onehot[i]) begin
        a_mux   = req_a[i*DATA_W +: DATA_W];
        b_mux   = req_b[i*DATA_W +: DATA_W];
        sel_mux = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          req_ready  = arb_onehot;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // --------------------------------------------------------------------------
  // State, operand, result and pointer registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_id    <= '0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      state <= state_next;

      // Operands stay on the ALU from this accept until the next one.
      if (accept) begin
        alu_a    <= a_mux;
        alu_b    <= b_mux;
        alu_sel  <= sel_mux;
        grant_id <= arb_idx;
      end

      // The ALU has had the whole EXEC cycle to settle on the held operands.
      if (state == EXEC) begin
        rsp_id    <= grant_id;
        rsp_out   <= alu_out;
        rsp_carry <= alu_carry;
        rsp_zero  <= alu_zero;
      end

      // Priority moves past the requester just served, wrapping to 0.
      if (rsp_fire) begin
        if (int'(grant_id) == NUM_REQ - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_id + ID_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Bench for alu_rr_scheduler with a behavioural ALU_8bit stand-in
//   (0 add, 1 sub with borrow, 2 and, 3 or, 4 xor, others pass A).
// ----------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int RW = 2 + DW + 2;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N*SW-1:0] req_sel = '0;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [SW-1:0]   alu_sel;
  logic [DW-1:0]   alu_out;
  logic            alu_carry;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_out;
  logic            rsp_carry;
  logic            rsp_zero;
  logic            busy;

  alu_rr_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  // Behavioural ALU: {carry, out}
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    case (sel)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h1:    return {1'b0, a} - {1'b0, b};
      4'h2:    return {1'b0, a & b};
      4'h3:    return {1'b0, a | b};
      4'h4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_zero = (alu_out == 8'h00);

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] sel);
    req_a[id*DW +: DW]   = a;
    req_b[id*DW +: DW]   = b;
    req_sel[id*SW +: SW] = sel;
  endtask

  // One complete op from a single requester, checked at every stage.
  task automatic run_single(input string tag, input int id, input logic [7:0] a,
                            input logic [7:0] b, input logic [3:0] sel,
                            input logic [7:0] eo, input logic ec, input logic ez);
    drive_req(id, a, b, sel);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    step();
    req_valid = '0;
    #1;
    check({tag, "_ops"}, 32'({alu_sel, alu_a, alu_b}), 32'({sel, a, b}));
    check({tag, "_exec"}, 32'({busy, rsp_valid, req_ready}), 32'({1'b1, 1'b0, 4'b0000}));
    step();
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero}),
          32'({1'b1, 2'(id), eo, ec, ez}));
    step();
    check({tag, "_idle"}, 32'({busy, rsp_valid}), 32'(2'b00));
  endtask

  // --------------------------------------------------------------------------
  // Table of single-op vectors
  // --------------------------------------------------------------------------
  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] out;
    logic       carry;
    logic       zero;
  } vec_t;

  vec_t vecs[8];

  // Random-phase model state
  logic       pend_v[N];
  logic [7:0] pend_a[N];
  logic [7:0] pend_b[N];
  logic [3:0] pend_s[N];
  int         model_ptr;

  task automatic apply_pend();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend_v[i];
      drive_req(i, pend_a[i], pend_b[i], pend_s[i]);
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'h0A, 8'h05, 4'h0, 8'h0F, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{2, 8'h0A, 8'h05, 4'h1, 8'h05, 1'b0, 1'b0};
    vecs[3] = '{3, 8'h05, 8'h0A, 4'h1, 8'hFB, 1'b1, 1'b0};
    vecs[4] = '{0, 8'hF0, 8'h3C, 4'h2, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hF0, 8'h0F, 4'h3, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{2, 8'hAA, 8'hAA, 4'h4, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{3, 8'h12, 8'h34, 4'hF, 8'h12, 1'b0, 1'b0};

    // ---------------- reset ----------------
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_ctrl", 32'({req_ready, rsp_valid, busy}), 32'(0));
    check("reset_alu", 32'({alu_sel, alu_a, alu_b}), 32'(0));
    check("reset_rsp", 32'({rsp_id, rsp_out, rsp_carry, rsp_zero}), 32'(0));

    // ---------------- table: single ops, incl. FF+01 carry/zero ----------------
    for (int v = 0; v < 8; v++) begin
      run_single($sformatf("vec%0d", v), vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sel,
                 vecs[v].out, vecs[v].carry, vecs[v].zero);
    end

    // ---------------- all four valid: order 0,1,2,3,0, one rsp per 3 cycles ----
    for (int i = 0; i < N; i++) drive_req(i, 8'(i * 16 + 1), 8'(i + 2), 4'h0);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      check($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1 << (g % N)));
      step();
      check($sformatf("rr_exec%0d", g), 32'({busy, rsp_valid}), 32'(2'b10));
      step();
      check($sformatf("rr_rsp%0d", g), 32'({rsp_valid, rsp_id, rsp_out}),
            32'({1'b1, 2'(g % N), 8'((g % N) * 16 + 1 + (g % N) + 2)}));
      step();
    end
    req_valid = '0;
    // last grant was 0, so priority now starts at 1

    // ---------------- wrap-around: rr_ptr=2, req1+req3 ----------------
    run_single("wrap_pre", 1, 8'h01, 8'h01, 4'h0, 8'h02, 1'b0, 1'b0);
    drive_req(1, 8'h10, 8'h01, 4'h0);
    drive_req(3, 8'h30, 8'h03, 4'h0);
    req_valid = 4'b1010;
    #1;
    check("wrap_first", 32'(req_ready), 32'(4'b1000));
    step();
    req_valid = 4'b0010;
    step();
    check("wrap_rsp3", 32'({rsp_valid, rsp_id, rsp_out}), 32'({1'b1, 2'd3, 8'h33}));
    step();
    #1;
    check("wrap_second", 32'(req_ready), 32'(4'b0010));
    step();
    req_valid = '0;
    step();
    check("wrap_rsp1", 32'({rsp_valid, rsp_id, rsp_out}), 32'({1'b1, 2'd1, 8'h11}));
    step();

    // ---------------- back-pressure ----------------
    drive_req(1, 8'h33, 8'h44, 4'h0);
    req_valid = 4'b0010;
    step();
    drive_req(0, 8'h01, 8'h02, 4'h0);
    req_valid = 4'b0001;
    step();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_hold%0d", k),
            32'({req_ready, busy, rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_zero}),
            32'({4'b0000, 1'b1, 1'b1, 2'd1, 8'h77, 1'b0, 1'b0}));
      step();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    check("bp_release", 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'd1}));
    step();
    check("bp_idle", 32'({busy, rsp_valid}), 32'(2'b00));

    // ---------------- reset during EXEC (rr_ptr is 2 here) ----------------
    drive_req(2, 8'h55, 8'h66, 4'h0);
    req_valid = 4'b0100;
    #1;
    check("rst_grant", 32'(req_ready), 32'(4'b0100));
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ctrl", 32'({busy, rsp_valid, req_ready}), 32'(0));
    check("rst_regs", 32'({alu_sel, alu_a, alu_b, rsp_id, rsp_out[3:0], rsp_carry, rsp_zero}),
          32'(0));
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (rsp_valid) seen = 1'b1;
        step();
      end
      check("rst_no_rsp", 32'(seen), 32'(0));
    end
    for (int i = 0; i < N; i++) drive_req(i, 8'(i + 1), 8'h01, 4'h0);
    req_valid = 4'b1111;
    #1;
    check("rst_ptr0", 32'(req_ready), 32'(4'b0001));
    step();
    req_valid = '0;
    step();
    check("rst_rsp0", 32'({rsp_valid, rsp_id, rsp_out}), 32'({1'b1, 2'd0, 8'h02}));
    step();
    model_ptr = 1;

    // ---------------- randomized traffic against a queue model ----------------
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
      pend_s[i] = '0;
    end
    for (int t = 0; t < 200; t++) begin
      int g;
      int done;
      int cyc;
      logic [8:0] r;
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          pend_v[i] = 1'b1;
          pend_a[i] = 8'($urandom_range(0, 255));
          pend_b[i] = 8'($urandom_range(0, 255));
          pend_s[i] = 4'($urandom_range(0, 15));
        end else if (pend_v[i] && $urandom_range(0, 9) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      apply_pend();
      #1;
      g = -1;
      for (int k = N - 1; k >= 0; k--) begin
        if (pend_v[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      end
      if (g < 0) begin
        check("rand_nogrant", 32'(req_ready), 32'(0));
        step();
        continue;
      end
      check("rand_grant", 32'(req_ready), 32'(1 << g));
      r = alu_fn(pend_a[g], pend_b[g], pend_s[g]);
      exp_q.push_back({2'(g), r[7:0], r[8], (r[7:0] == 8'h00)});
      model_ptr = (g + 1) % N;
      step();
      pend_v[g] = 1'b0;
      apply_pend();
      done = 0;
      cyc  = 0;
      while (done == 0 && cyc < 40) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        check("rand_wait_ready", 32'(req_ready), 32'(0));
        if (rsp_valid && rsp_ready) begin
          check("rand_rsp", 32'({rsp_id, rsp_out, rsp_carry, rsp_zero}),
                32'(exp_q.pop_front()));
          done = 1;
        end
        step();
        cyc++;
      end
      if (done == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rand_timeout: no response within %0d cycles", cyc);
        void'(exp_q.pop_front());
      end
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
